simple_ppu_cmd_seq: RTL and testbench
=====================================

// Module: simple_ppu_cmd_seq
// PURPOSE
//  Parametrised command-list sequencer. On start it fetches a word-addressed command list from
//  shared memory, gathers each opcode's arguments and dispatches drawing ops to the PPU engine.
//  Adds a RD_LAT-configurable read pipeline, wide argument bus, JUMP and single-level LOOP opcodes,
//  abort and error reporting. Sits between the core memory arbiter and the PPU draw engine.
// PARAMETERS
//  ADDR_W    24  memory word-address width
//  MAX_ARGS  7   argument slots on ppu_args (>=6)
//  RD_LAT    2   cycles from accepted mem_rd to valid mem_q (>=1)
//  CNT_W     16  width of cmd_count and loop counter
// PORTS
//  clk         in   1               single clock
//  reset       in   1               synchronous, active-high
//  start       in   1               pulse: latch list_base/list_len, begin run
//  abort       in   1               pulse/level: stop run at next safe point
//  list_base   in   ADDR_W          first word address of list
//  list_len    in   ADDR_W          list length in words
//  busy        out  1               run in progress
//  done        out  1               one-cycle pulse at end of run (normal, abort or error)
//  aborted     out  1               held from done until next start
//  error       out  1               held from done until next start
//  err_code    out  3               1 BADOP, 2 TRUNC, 3 JUMP, 4 LOOP; 0 none
//  cmd_count   out  CNT_W           PPU ops dispatched this run, saturating
//  mem_rd      out  1               one-cycle read strobe
//  mem_addr    out  ADDR_W          list_base + pc
//  mem_q       in   32              read data
//  mem_busy    in   1               arbiter busy; mem_rd issued only when low
//  ppu_start   out  1               one-cycle dispatch pulse
//  ppu_opcode  out  8               opcode of dispatched op
//  ppu_args    out  32*MAX_ARGS     arg k in bits [32k+31:32k]; unused slots zero
//  ppu_done    in   1               PPU completion pulse
// BEHAVIOUR
//  - Reset: every output 0, state IDLE, pc 0, loop inactive. Reset mid-run drops run, no done.
//  - Opcode word: opcode in mem_q[31:24], rest ignored. Arg counts: 01 CLEAR 1, 02 PLOT 3,
//    03 LINE 5, 04 RECT 6, 05 LOOP 1, 06 ENDLOOP 0, 07 JUMP 1, FF END 0; others BADOP.
//  - FSM: IDLE -> OP_REQ -> OP_WAIT(RD_LAT cycles) -> OP_LATCH -> [ARG_REQ -> ARG_WAIT -> ARG_LATCH]*
//    -> EXEC -> (PPU_WAIT) -> OP_REQ; terminal DONE (1 cycle, done=1) -> IDLE.
//  - start in IDLE: latch base/len, pc=0, clear cmd_count/error/aborted, busy=1; first mem_rd the
//    cycle after start unless mem_busy. start while busy ignored.
//  - mem_rd only in *_REQ with mem_busy low; REQ holds while mem_busy high. mem_q sampled exactly
//    RD_LAT cycles after mem_rd. pc increments per word consumed; pc is ADDR_W wide.
//  - OP_REQ with pc >= len: normal end (no error). ARG_REQ with pc >= len: error TRUNC.
//  - EXEC: draw ops pulse ppu_start with opcode/args stable until ppu_done; cmd_count++ (sat).
//    END -> DONE. JUMP: arg0 >= len -> error JUMP, else pc = arg0[ADDR_W-1:0].
//    LOOP: if loop active -> error LOOP; else loop_pc = pc, loop_cnt = max(arg0[CNT_W-1:0],1).
//    ENDLOOP: inactive -> error LOOP; loop_cnt > 1 -> decrement, pc = loop_pc; ==1 -> deactivate.
//  - Errors go to DONE with error=1, err_code set; first error wins.
//  - abort: in PPU_WAIT waits for ppu_done, then DONE; in any wait for mem read completes that read
//    first; elsewhere DONE next cycle. aborted=1. abort in IDLE ignored; start+abort same cycle in
//    IDLE: abort ignored, run starts.
//  - ppu_done outside PPU_WAIT ignored. ppu_args slots >= op arg count zeroed at OP_LATCH.
// STRUCTURE
//  - simple_ppu_pkg: opcode localparams, err codes, function op_arg_count(opcode)->{valid,count}.
//  - Sub-module simple_ppu_rd_pipe: RD_LAT-deep shift of the rd strobe giving q_valid; FSM waits on
//    q_valid instead of counting. Everything else in this module.
// TESTING
//  - list {02000000,5,7,3F, FF000000}, len 5, RD_LAT 2 -> one ppu_start, op 02, args 5,7,3F,0..;
//    done after ppu_done, cmd_count 1, error 0.
//  - LOOP 3 {05000000,3, 01000000,0, 06000000, FF000000} -> 3 CLEAR dispatches, cmd_count 3.
//  - JUMP to 9 with len 6 -> no dispatch, done, error 1, err_code 3; ENDLOOP first -> err_code 4.
//  - RECT with len cut at 4 words -> err_code 2; opcode 0x42 -> err_code 1.
//  - abort during PPU_WAIT -> done only one cycle after ppu_done, aborted 1, no further mem_rd.
//  - mem_busy held high 5 cycles in OP_REQ -> mem_rd delayed to first free cycle; RD_LAT=4 rerun
//    of case 1 -> identical args and dispatch count.

Source files
------------

// File: rtl/simple_ppu_pkg.sv
// Shared definitions for the PPU command-list sequencer: opcodes, error codes,
// FSM states and the per-opcode argument-count decoder.
package simple_ppu_pkg;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_PLOT    = 8'h02;
    localparam logic [7:0] OP_LINE    = 8'h03;
    localparam logic [7:0] OP_RECT    = 8'h04;
    localparam logic [7:0] OP_LOOP    = 8'h05;
    localparam logic [7:0] OP_ENDLOOP = 8'h06;
    localparam logic [7:0] OP_JUMP    = 8'h07;
    localparam logic [7:0] OP_END     = 8'hFF;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_BADOP = 3'd1;
    localparam logic [2:0] ERR_TRUNC = 3'd2;
    localparam logic [2:0] ERR_JUMP  = 3'd3;
    localparam logic [2:0] ERR_LOOP  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OP_REQ,
        S_OP_WAIT,
        S_OP_LATCH,
        S_ARG_REQ,
        S_ARG_WAIT,
        S_ARG_LATCH,
        S_EXEC,
        S_PPU_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] count;
    } arg_info_t;

    function automatic arg_info_t op_arg_count(input logic [7:0] opcode);
        arg_info_t info;
        info = '{valid: 1'b1, count: 3'd0};
        case (opcode)
            OP_CLEAR:   info.count = 3'd1;
            OP_PLOT:    info.count = 3'd3;
            OP_LINE:    info.count = 3'd5;
            OP_RECT:    info.count = 3'd6;
            OP_LOOP:    info.count = 3'd1;
            OP_ENDLOOP: info.count = 3'd0;
            OP_JUMP:    info.count = 3'd1;
            OP_END:     info.count = 3'd0;
            default:    info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/simple_ppu_rd_pipe.sv
// Delays the memory read strobe by RD_LAT cycles so the sequencer knows the
// exact cycle in which mem_q carries the requested word.
module simple_ppu_rd_pipe #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rd,
    output logic q_valid
);
    logic [RD_LAT-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= rd;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q_valid = stage[RD_LAT-1];

endmodule

// File: rtl/simple_ppu_cmd_seq.sv
// Command-list sequencer: fetches opcode and argument words from shared memory,
// handles JUMP/LOOP flow control and dispatches drawing ops to the PPU engine.
module simple_ppu_cmd_seq
    import simple_ppu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned MAX_ARGS = 7,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      list_base,
    input  logic [ADDR_W-1:0]      list_len,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   error,
    output logic [2:0]             err_code,
    output logic [CNT_W-1:0]       cmd_count,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [31:0]            mem_q,
    input  logic                   mem_busy,
    output logic                   ppu_start,
    output logic [7:0]             ppu_opcode,
    output logic [32*MAX_ARGS-1:0] ppu_args,
    input  logic                   ppu_done
);
    localparam int unsigned AIW = $clog2(MAX_ARGS + 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] base, base_next, len, len_next, pc, pc_next, loop_pc, loop_pc_next;
    logic [CNT_W-1:0]  loop_cnt, loop_cnt_next, cmd_count_next;
    logic              loop_on, loop_on_next, abort_pend, abort_pend_next;
    logic              aborted_next, error_next;
    logic [2:0]        err_code_next, fail_code;
    logic [7:0]        opcode_next;
    logic [31:0]       rdata, rdata_next;
    logic [31:0]       args [MAX_ARGS];
    logic [31:0]       args_next [MAX_ARGS];
    logic [AIW-1:0]    arg_idx, arg_idx_next, arg_num, arg_num_next;
    logic              q_valid, stop, finish, fail;
    arg_info_t         info;

    simple_ppu_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .rd      (mem_rd),
        .q_valid (q_valid)
    );

    assign stop     = abort | abort_pend;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);
    assign mem_addr = base + pc;

    always_comb begin
        ppu_args = '0;
        for (int unsigned k = 0; k < MAX_ARGS; k++) begin
            ppu_args[32*k +: 32] = args[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            base       <= '0;
            len        <= '0;
            pc         <= '0;
            loop_pc    <= '0;
            loop_cnt   <= '0;
            loop_on    <= 1'b0;
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            cmd_count  <= '0;
            ppu_opcode <= '0;
            rdata      <= '0;
            arg_idx    <= '0;
            arg_num    <= '0;
            for (int unsigned k = 0; k < MAX_ARGS; k++) args[k] <= '0;
        end else begin
            state      <= state_next;
            base       <= base_next;
            len        <= len_next;
            pc         <= pc_next;
            loop_pc    <= loop_pc_next;
            loop_cnt   <= loop_cnt_next;
            loop_on    <= loop_on_next;
            abort_pend <= abort_pend_next;
            aborted    <= aborted_next;
            error      <= error_next;
            err_code   <= err_code_next;
            cmd_count  <= cmd_count_next;
            ppu_opcode <= opcode_next;
            rdata      <= rdata_next;
            arg_idx    <= arg_idx_next;
            arg_num    <= arg_num_next;
            for (int unsigned k = 0; k < MAX_ARGS; k++) args[k] <= args_next[k];
        end
    end

    always_comb begin
        state_next      = state;
        base_next       = base;
        len_next        = len;
        pc_next         = pc;
        loop_pc_next    = loop_pc;
        loop_cnt_next   = loop_cnt;
        loop_on_next    = loop_on;
        abort_pend_next = abort_pend;
        aborted_next    = aborted;
        error_next      = error;
        err_code_next   = err_code;
        cmd_count_next  = cmd_count;
        opcode_next     = ppu_opcode;
        rdata_next      = rdata;
        arg_idx_next    = arg_idx;
        arg_num_next    = arg_num;
        args_next       = args;
        info            = op_arg_count(rdata[31:24]);
        mem_rd          = 1'b0;
        ppu_start       = 1'b0;
        finish          = 1'b0;
        fail            = 1'b0;
        fail_code       = ERR_NONE;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next      = S_OP_REQ;
                    base_next       = list_base;
                    len_next        = list_len;
                    pc_next         = '0;
                    loop_on_next    = 1'b0;
                    abort_pend_next = 1'b0;
                    aborted_next    = 1'b0;
                    error_next      = 1'b0;
                    err_code_next   = ERR_NONE;
                    cmd_count_next  = '0;
                end
            end
            S_OP_REQ, S_ARG_REQ: begin
                if (stop) begin
                    finish = 1'b1;
                end else if (pc >= len) begin
                    // Running out of words between ops is a normal end, mid-op it is truncation.
                    if (state == S_OP_REQ) finish = 1'b1;
                    else begin
                        fail      = 1'b1;
                        fail_code = ERR_TRUNC;
                    end
                end else if (!mem_busy) begin
                    mem_rd     = 1'b1;
                    state_next = (state == S_OP_REQ) ? S_OP_WAIT : S_ARG_WAIT;
                end
            end
            S_OP_WAIT, S_ARG_WAIT: begin
                if (q_valid) begin
                    rdata_next = mem_q;
                    pc_next    = pc + ADDR_W'(1);
                    if (stop) finish = 1'b1;
                    else state_next = (state == S_OP_WAIT) ? S_OP_LATCH : S_ARG_LATCH;
                end
            end
            S_OP_LATCH: begin
                if (stop) begin
                    finish = 1'b1;
                end else begin
                    opcode_next  = rdata[31:24];
                    arg_idx_next = '0;
                    arg_num_next = AIW'(info.count);
                    for (int unsigned k = 0; k < MAX_ARGS; k++) args_next[k] = '0;
                    if (!info.valid) begin
                        fail      = 1'b1;
                        fail_code = ERR_BADOP;
                    end else begin
                        state_next = (info.count == 3'd0) ? S_EXEC : S_ARG_REQ;
                    end
                end
            end
            S_ARG_LATCH: begin
                args_next[arg_idx] = rdata;
                arg_idx_next       = arg_idx + AIW'(1);
                if (stop) finish = 1'b1;
                else state_next = (arg_idx + AIW'(1) == arg_num) ? S_EXEC : S_ARG_REQ;
            end
            S_EXEC: begin
                if (stop) begin
                    finish = 1'b1;
                end else begin
                    state_next = S_OP_REQ;
                    case (ppu_opcode)
                        OP_CLEAR, OP_PLOT, OP_LINE, OP_RECT: begin
                            ppu_start  = 1'b1;
                            state_next = S_PPU_WAIT;
                            if (cmd_count != '1) cmd_count_next = cmd_count + CNT_W'(1);
                        end
                        OP_END: finish = 1'b1;
                        OP_JUMP: begin
                            if (args[0] >= 32'(len)) begin
                                fail      = 1'b1;
                                fail_code = ERR_JUMP;
                            end else begin
                                pc_next = args[0][ADDR_W-1:0];
                            end
                        end
                        OP_LOOP: begin
                            if (loop_on) begin
                                fail      = 1'b1;
                                fail_code = ERR_LOOP;
                            end else begin
                                loop_on_next  = 1'b1;
                                loop_pc_next  = pc;
                                loop_cnt_next = (args[0][CNT_W-1:0] == '0) ? CNT_W'(1)
                                                                           : args[0][CNT_W-1:0];
                            end
                        end
                        OP_ENDLOOP: begin
                            if (!loop_on) begin
                                fail      = 1'b1;
                                fail_code = ERR_LOOP;
                            end else if (loop_cnt > CNT_W'(1)) begin
                                loop_cnt_next = loop_cnt - CNT_W'(1);
                                pc_next       = loop_pc;
                            end else begin
                                loop_on_next = 1'b0;
                            end
                        end
                        default: begin
                            fail      = 1'b1;
                            fail_code = ERR_BADOP;
                        end
                    endcase
                end
            end
            S_PPU_WAIT: begin
                if (ppu_done) begin
                    if (stop) finish = 1'b1;
                    else state_next = S_OP_REQ;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (abort && state != S_IDLE && state != S_DONE) abort_pend_next = 1'b1;
        if (fail) begin
            error_next    = 1'b1;
            err_code_next = fail_code;
            finish        = 1'b1;
        end
        if (finish) begin
            state_next = S_DONE;
            if (stop) aborted_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_simple_ppu_cmd_seq.sv
// Scoreboard bench for simple_ppu_cmd_seq: two instances (RD_LAT 2 and 4) share
// a word memory; expected dispatches are queued at start and popped on ppu_start.
module tb_simple_ppu_cmd_seq;
    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned MAX_ARGS = 7;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned LAT_A    = 2;
    localparam int unsigned LAT_B    = 4;
    localparam int unsigned AW       = 32 * MAX_ARGS;

    typedef struct packed {
        logic [7:0]    op;
        logic [AW-1:0] args;
    } disp_t;

    logic clk = 1'b0;
    logic reset, start, abort, mem_busy, ppu_done;
    logic [ADDR_W-1:0] list_base, list_len;
    logic sel;

    logic busy_a, done_a, aborted_a, error_a, mem_rd_a, ppu_start_a;
    logic busy_b, done_b, aborted_b, error_b, mem_rd_b, ppu_start_b;
    logic [2:0] err_code_a, err_code_b;
    logic [CNT_W-1:0] cmd_count_a, cmd_count_b;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
    logic [31:0] mem_q_a, mem_q_b;
    logic [7:0] ppu_opcode_a, ppu_opcode_b;
    logic [AW-1:0] ppu_args_a, ppu_args_b;
    logic start_a, start_b, abort_a, abort_b;

    logic obs_busy, obs_done, obs_aborted, obs_error, obs_mem_rd, obs_ppu_start;
    logic [2:0] obs_err_code;
    logic [CNT_W-1:0] obs_cmd_count;
    logic [ADDR_W-1:0] obs_mem_addr;
    logic [7:0] obs_opcode;
    logic [AW-1:0] obs_args;

    logic [31:0] mem [256];
    logic [31:0] pipe_a [LAT_A];
    logic [31:0] pipe_b [LAT_B];
    logic [31:0] prog [$];
    disp_t sb [$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, pd_cyc = 0, done_cyc = 0, rd_seen = 0, ppu_dly = 2;
    logic count_rd = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign abort_a = abort & ~sel;
    assign abort_b = abort & sel;

    assign obs_busy      = sel ? busy_b : busy_a;
    assign obs_done      = sel ? done_b : done_a;
    assign obs_aborted   = sel ? aborted_b : aborted_a;
    assign obs_error     = sel ? error_b : error_a;
    assign obs_err_code  = sel ? err_code_b : err_code_a;
    assign obs_cmd_count = sel ? cmd_count_b : cmd_count_a;
    assign obs_mem_rd    = sel ? mem_rd_b : mem_rd_a;
    assign obs_mem_addr  = sel ? mem_addr_b : mem_addr_a;
    assign obs_ppu_start = sel ? ppu_start_b : ppu_start_a;
    assign obs_opcode    = sel ? ppu_opcode_b : ppu_opcode_a;
    assign obs_args      = sel ? ppu_args_b : ppu_args_a;

    simple_ppu_cmd_seq #(.ADDR_W(ADDR_W), .MAX_ARGS(MAX_ARGS), .RD_LAT(LAT_A), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .list_base(list_base), .list_len(list_len),
        .busy(busy_a), .done(done_a), .aborted(aborted_a), .error(error_a),
        .err_code(err_code_a), .cmd_count(cmd_count_a),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_q(mem_q_a), .mem_busy(mem_busy),
        .ppu_start(ppu_start_a), .ppu_opcode(ppu_opcode_a), .ppu_args(ppu_args_a),
        .ppu_done(ppu_done)
    );

    simple_ppu_cmd_seq #(.ADDR_W(ADDR_W), .MAX_ARGS(MAX_ARGS), .RD_LAT(LAT_B), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .list_base(list_base), .list_len(list_len),
        .busy(busy_b), .done(done_b), .aborted(aborted_b), .error(error_b),
        .err_code(err_code_b), .cmd_count(cmd_count_b),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_q(mem_q_b), .mem_busy(mem_busy),
        .ppu_start(ppu_start_b), .ppu_opcode(ppu_opcode_b), .ppu_args(ppu_args_b),
        .ppu_done(ppu_done)
    );

    // Memory returns the word exactly LAT cycles after the strobe, poison otherwise.
    always @(posedge clk) begin
        pipe_a[0] <= mem_rd_a ? mem[mem_addr_a[7:0]] : 32'hDEADBEEF;
        for (int unsigned i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        pipe_b[0] <= mem_rd_b ? mem[mem_addr_b[7:0]] : 32'hDEADBEEF;
        for (int unsigned i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign mem_q_a = pipe_a[LAT_A-1];
    assign mem_q_b = pipe_b[LAT_B-1];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [31:0] a0, a1, a2, a3, a4, a5);
        disp_t e;
        e.op   = op;
        e.args = {32'h0, a5, a4, a3, a2, a1, a0};
        sb.push_back(e);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 32'hEE000000;
        for (int i = 0; i < prog.size(); i++) mem[16 + i] = prog[i];
    endtask

    task automatic start_run(input int len, input logic with_abort);
        @(negedge clk);
        list_base = 16;
        list_len  = ADDR_W'(len);
        start     = 1'b1;
        abort     = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic finish_run(input string name, input logic err, input logic [2:0] code,
                              input int cnt, input logic ab);
        logic ok;
        int c;
        ok = 1'b0;
        c  = 0;
        while (!ok && c < 3000) begin
            @(negedge clk);
            if (obs_done) begin
                ok       = 1'b1;
                done_cyc = cyc;
            end
            c++;
        end
        check({name, ":done_seen"}, ok, 1);
        check({name, ":error"}, obs_error, err);
        check({name, ":err_code"}, obs_err_code, code);
        check({name, ":cmd_count"}, obs_cmd_count, cnt);
        check({name, ":aborted"}, obs_aborted, ab);
        check({name, ":missing_dispatch"}, sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check({name, ":idle"}, {obs_busy, obs_done}, 0);
    endtask

    // PPU model: completes each dispatched op ppu_dly cycles later.
    initial begin
        ppu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (obs_ppu_start) begin
                repeat (ppu_dly) @(negedge clk);
                ppu_done = 1'b1;
                pd_cyc   = cyc;
                @(negedge clk);
                ppu_done = 1'b0;
            end
        end
    end

    initial begin
        disp_t e;
        forever begin
            @(negedge clk);
            if (count_rd && obs_mem_rd) rd_seen++;
            if (obs_ppu_start) begin
                if (sb.size() == 0) begin
                    check("unexpected_dispatch", obs_opcode, 0);
                end else begin
                    e = sb.pop_front();
                    check("ppu_opcode", obs_opcode, e.op);
                    check("ppu_args", obs_args, e.args);
                end
            end
        end
    end

    initial begin
        int busy_rd;
        reset = 1'b1; start = 1'b0; abort = 1'b0; mem_busy = 1'b0; sel = 1'b0;
        list_base = '0; list_len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset:flags", {obs_busy, obs_done, obs_aborted, obs_error, obs_mem_rd, obs_ppu_start}, 0);
        check("reset:err_code", obs_err_code, 0);
        check("reset:cmd_count", obs_cmd_count, 0);
        check("reset:addr_args", {obs_mem_addr, obs_opcode, obs_args}, 0);

        prog = '{32'h02000000, 5, 7, 32'h3F, 32'hFF000000};
        load_prog();
        push_exp(8'h02, 5, 7, 32'h3F, 0, 0, 0);
        start_run(5, 1'b0);
        finish_run("plot", 0, 0, 1, 0);

        prog = '{32'h05000000, 3, 32'h01000000, 32'h11, 32'h06000000, 32'hFF000000};
        load_prog();
        repeat (3) push_exp(8'h01, 32'h11, 0, 0, 0, 0, 0);
        start_run(6, 1'b0);
        finish_run("loop3", 0, 0, 3, 0);

        prog = '{32'h05000000, 0, 32'h01000000, 32'h44, 32'h06000000};
        load_prog();
        push_exp(8'h01, 32'h44, 0, 0, 0, 0, 0);
        start_run(5, 1'b0);
        finish_run("loop0", 0, 0, 1, 0);

        prog = '{32'h03000000, 1, 2, 3, 4, 5, 32'h01000000, 32'h55, 32'hFF000000};
        load_prog();
        push_exp(8'h03, 1, 2, 3, 4, 5, 0);
        push_exp(8'h01, 32'h55, 0, 0, 0, 0, 0);
        start_run(9, 1'b0);
        finish_run("line_clear", 0, 0, 2, 0);

        prog = '{32'h07000000, 3, 32'hFF000000, 32'h01000000, 32'h22, 32'hFF000000};
        load_prog();
        push_exp(8'h01, 32'h22, 0, 0, 0, 0, 0);
        start_run(6, 1'b0);
        finish_run("jump_ok", 0, 0, 1, 0);

        prog = '{32'h07000000, 9, 32'h01000000, 1, 32'hFF000000, 0};
        load_prog();
        start_run(6, 1'b0);
        finish_run("jump9", 1, 3, 0, 0);

        prog = '{32'h07000000, 6, 32'h01000000, 1, 32'hFF000000, 0};
        load_prog();
        start_run(6, 1'b0);
        finish_run("jump_eq_len", 1, 3, 0, 0);

        prog = '{32'h06000000, 32'hFF000000};
        load_prog();
        start_run(2, 1'b0);
        finish_run("endloop_first", 1, 4, 0, 0);

        prog = '{32'h05000000, 2, 32'h05000000, 2};
        load_prog();
        start_run(4, 1'b0);
        finish_run("nested_loop", 1, 4, 0, 0);

        prog = '{32'h04000000, 1, 2, 3, 4, 5, 6};
        load_prog();
        start_run(4, 1'b0);
        finish_run("rect_trunc", 1, 2, 0, 0);

        prog = '{32'h42000000};
        load_prog();
        start_run(1, 1'b0);
        finish_run("badop", 1, 1, 0, 0);

        // start and abort together in IDLE: abort has no effect
        prog = '{32'h01000000, 32'h33};
        load_prog();
        push_exp(8'h01, 32'h33, 0, 0, 0, 0, 0);
        start_run(2, 1'b1);
        finish_run("no_end", 0, 0, 1, 0);

        prog = '{32'h02000000, 5, 7, 32'h3F, 32'hFF000000};
        load_prog();
        ppu_dly = 10;
        push_exp(8'h02, 5, 7, 32'h3F, 0, 0, 0);
        start_run(5, 1'b0);
        begin
            int c;
            c = 0;
            while (!obs_ppu_start && c < 200) begin
                @(negedge clk);
                c++;
            end
            check("abort:dispatch_seen", obs_ppu_start, 1);
        end
        @(negedge clk);
        abort    = 1'b1;
        rd_seen  = 0;
        count_rd = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        finish_run("abort", 0, 0, 1, 1);
        check("abort:done_after_ppu_done", done_cyc - pd_cyc, 1);
        repeat (4) @(negedge clk);
        count_rd = 1'b0;
        check("abort:no_mem_rd", rd_seen, 0);
        check("abort:held", obs_aborted, 1);
        ppu_dly = 2;

        load_prog();
        push_exp(8'h02, 5, 7, 32'h3F, 0, 0, 0);
        @(negedge clk);
        list_base = 16;
        list_len  = 5;
        start     = 1'b1;
        mem_busy  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        busy_rd = 0;
        for (int i = 0; i < 5; i++) begin
            if (obs_mem_rd) busy_rd++;
            @(negedge clk);
        end
        check("busy:no_rd", busy_rd, 0);
        mem_busy = 1'b0;
        #1;
        check("busy:rd_when_free", obs_mem_rd, 1);
        check("busy:addr", obs_mem_addr, 16);
        finish_run("busy", 0, 0, 1, 0);

        sel = 1'b1;
        push_exp(8'h02, 5, 7, 32'h3F, 0, 0, 0);
        start_run(5, 1'b0);
        finish_run("lat4", 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
